// File: rtl/program_loader.sv
// Byte-stream program loader: parses a length-prefixed, checksummed word stream
// and writes each 16-bit word into instruction memory while holding the CPU.
module program_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK_HI,
    S_CHK_LO,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        accept;
  logic [15:0] word;
  logic [15:0] cnt_inc;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;

    byte_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO)  ||
                 (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                 (state_q == S_CHK_HI)  || (state_q == S_CHK_LO);
    accept  = byte_valid && byte_ready;
    word    = {hi_q, byte_data};
    cnt_inc = cnt_q + 16'd1;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          hi_d    = byte_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = word;
          if (word == '0)                   state_d = S_CHK_HI;
          else if ({1'b0, word} > DEPTH_W)  state_d = S_ERR;
          else                              state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hi_d    = byte_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        // Address/data are captured here so they are stable for the whole WRITE cycle
        // and keep their value afterwards.
        if (accept) begin
          addr_d  = cnt_q;
          data_d  = word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_inc;
        sum_d   = sum_q + data_q;
        state_d = (cnt_inc == len_q) ? S_CHK_HI : S_DATA_HI;
      end
      S_CHK_HI: begin
        if (accept) begin
          hi_d    = byte_data;
          state_d = S_CHK_LO;
        end
      end
      S_CHK_LO: begin
        if (accept) state_d = (word == sum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = (state_q == S_WRITE);
  assign cpu_hold    = (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERR);

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 256, is the maximum number of 16-bit instruction words accepted (instruction memory depth).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 start  input  1  one-cycle request to begin a load; ignored outside IDLE, DONE and ERR.
REQ-005 byte_valid  input  1  byte_data is valid this cycle.
REQ-006 byte_data  input  8  incoming stream byte.
REQ-007 byte_ready  output  1  loader accepts byte_data this cycle; transfer occurs when byte_valid && byte_ready.
REQ-008 mem_address  output  16  instruction memory write address (word index).
REQ-009 mem_data  output  16  instruction word to write.
REQ-010 mem_wren  output  1  one-cycle write strobe to instruction memory.
REQ-011 cpu_hold  output  1  holds the CPU pipeline (PC register and pipeline registers) in reset while high.
REQ-012 done  output  1  load completed with valid checksum; level, held until next start or reset.
REQ-013 error  output  1  load aborted (length > DEPTH or checksum mismatch); level, held until next start or reset.

Function
REQ-014 Stream format, all fields big-endian: length N (2 bytes), then N words (2 bytes each, high byte first), then checksum (2 bytes) = 16-bit wrap-around sum of the N words.
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHK_HI, CHK_LO, DONE, ERR.
REQ-016 IDLE/DONE/ERR --start--> LEN_HI; done, error cleared, word counter and running sum cleared on the same edge.
REQ-017 byte_ready is high only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK_HI, CHK_LO; each such state advances only on an accepted byte and otherwise holds indefinitely.
REQ-018 LEN_LO on accept: N = 0 -> CHK_HI; N > DEPTH -> ERR; otherwise -> DATA_HI.
REQ-019 DATA_LO on accept -> WRITE; assembled word = {high byte, low byte}.
REQ-020 WRITE lasts exactly one cycle: mem_wren = 1, mem_address = word counter (first word at 0), mem_data = assembled word; on exit counter increments and word is added to the running sum modulo 2^16.
REQ-021 WRITE exits to CHK_HI when incremented counter equals N, else to DATA_HI.
REQ-022 CHK_LO on accept: received checksum equals running sum -> DONE, else -> ERR.
REQ-023 Latency: mem_wren asserts in the cycle immediately after the low byte of a word is accepted; minimum 3 cycles per word.
REQ-024 mem_wren is 0 in every state except WRITE; mem_address and mem_data hold their last values outside WRITE.
REQ-025 cpu_hold is 1 in every state except DONE; a load that ends in ERR keeps the CPU held.
REQ-026 start asserted during an in-progress load (LEN_HI..CHK_LO) is ignored.
REQ-027 byte_valid with byte_ready low is not consumed; the source must hold the byte.

Reset
REQ-028 reset has priority over all inputs: state = IDLE, counter = 0, sum = 0, mem_address = 0, mem_data = 0, mem_wren = 0, byte_ready = 0, done = 0, error = 0, cpu_hold = 1.
REQ-029 reset asserted mid-load aborts immediately; no mem_wren on the reset edge or the following cycle; words already written are not undone.

Verification
REQ-030 Nominal: start, stream 00 02 | 12 34 | AB CD | BE 01 -> writes (0,0x1234), (1,0xABCD), done = 1, error = 0, cpu_hold falls in the DONE cycle.
REQ-031 Bad checksum: 00 01 | 00 05 | 00 06 -> one write (0,0x0005), error = 1, done = 0, cpu_hold stays 1.
REQ-032 Length overflow with DEPTH = 256: 01 01 -> ERR after second byte, no mem_wren ever asserted.
REQ-033 Zero length: 00 00 | 00 00 -> no writes, done = 1; 00 00 | 00 01 -> error = 1.
REQ-034 Backpressure and gaps: byte_valid toggled randomly plus byte_valid high during WRITE -> byte never consumed while byte_ready = 0, write sequence identical to REQ-030.
REQ-035 Reset mid-load: assert reset in DATA_LO of word 1 -> all outputs at REQ-028 values next cycle; fresh start then completes REQ-030 correctly.
